// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared GCD state encoding and default sizing constants
package gcd_pkg;

    localparam int GCD_DATA_BITS = 4;
    localparam int GCD_ITER_BITS = 4;
    localparam int GCD_MAX_ITER  = 15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CMP  = 3'd2,
        S_SUBX = 3'd3,
        S_SUBY = 3'd4,
        S_OUT  = 3'd5,
        S_DONE = 3'd6
    } gcd_state_e;

endpackage

// File: rtl/gcd_iter_counter.sv
// rtl/gcd_iter_counter.sv - saturating subtraction counter with limit compare
module gcd_iter_counter
    import gcd_pkg::*;
#(
    parameter int ITER_BITS = GCD_ITER_BITS,
    parameter int MAX_ITER  = GCD_MAX_ITER
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic limit_o
);

    logic [ITER_BITS-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {ITER_BITS{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign limit_o = (cnt_q == ITER_BITS'(MAX_ITER));

endmodule

// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - Moore FSM sequencing the subtractive GCD datapath
// GCD_CTRL_ITER_LIMIT_EN enables the iteration counter and error abort path.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int DATA_BITS = GCD_DATA_BITS,
    parameter int ITER_BITS = GCD_ITER_BITS,
    parameter int MAX_ITER  = GCD_MAX_ITER
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic ack_i,
    input  logic xbig_i,
    input  logic ybig_i,
    input  logic eq_i,
    output logic sx_o,
    output logic sy_o,
    output logic ssub_o,
    output logic enx_o,
    output logic eny_o,
    output logic enobeb_o,
    output logic busy_o,
    output logic done_o,
    output logic err_o
);

    gcd_state_e state_q, state_d;
    logic       limit;
    logic       err_q;
    logic       unused_cfg;

    assign unused_cfg = ^{DATA_BITS, ITER_BITS, MAX_ITER};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_LOAD;
            S_LOAD: state_d = S_CMP;
            S_CMP: begin
                if (eq_i)        state_d = S_OUT;
                else if (limit)  state_d = S_DONE;
                else if (ybig_i) state_d = S_SUBY;
                else if (xbig_i) state_d = S_SUBX;
                else             state_d = S_OUT;
            end
            S_SUBX, S_SUBY: state_d = S_CMP;
            S_OUT:  state_d = S_DONE;
            S_DONE: if (ack_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef GCD_CTRL_ITER_LIMIT_EN
    gcd_iter_counter #(
        .ITER_BITS(ITER_BITS),
        .MAX_ITER (MAX_ITER)
    ) u_iter_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_q == S_LOAD),
        .inc_i  ((state_q == S_CMP) && ((state_d == S_SUBX) || (state_d == S_SUBY))),
        .limit_o(limit)
    );

    // Only the CMP-to-DONE path bypasses OUT, so it marks the abort.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (state_q == S_LOAD) begin
            err_q <= 1'b0;
        end else if ((state_q == S_CMP) && (state_d == S_DONE)) begin
            err_q <= 1'b1;
        end
    end
`else
    assign limit = 1'b0;
    assign err_q = 1'b0;
`endif

    always_comb begin
        sx_o     = 1'b0;
        sy_o     = 1'b0;
        ssub_o   = 1'b0;
        enx_o    = 1'b0;
        eny_o    = 1'b0;
        enobeb_o = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        err_o    = 1'b0;
        case (state_q)
            S_LOAD: begin
                enx_o  = 1'b1;
                eny_o  = 1'b1;
                busy_o = 1'b1;
            end
            S_CMP:  busy_o = 1'b1;
            S_SUBX: begin
                sx_o   = 1'b1;
                enx_o  = 1'b1;
                busy_o = 1'b1;
            end
            S_SUBY: begin
                sy_o   = 1'b1;
                ssub_o = 1'b1;
                eny_o  = 1'b1;
                busy_o = 1'b1;
            end
            S_OUT: begin
                enobeb_o = 1'b1;
                busy_o   = 1'b1;
            end
            S_DONE: begin
                done_o = 1'b1;
                err_o  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gcd_controller.sv
// tb/tb_gcd_controller.sv - randomized self-checking bench with a behavioural datapath
module tb_gcd_controller;

    logic clk_i, rst_ni, start_i, ack_i;
    logic xbig_i, ybig_i, eq_i;
    logic sx_o, sy_o, ssub_o, enx_o, eny_o, enobeb_o, busy_o, done_o, err_o;
    logic [3:0] op_a, op_b, dp_x, dp_y, dp_obeb;
    int checks = 0;
    int errors = 0;

`ifdef GCD_CTRL_ITER_LIMIT_EN
    localparam int REF_LIMIT = gcd_pkg::GCD_MAX_ITER;
`else
    localparam int REF_LIMIT = 1000;
`endif

    localparam logic [8:0] P_IDLE     = 9'b000_000_000;
    localparam logic [8:0] P_LOAD     = 9'b000_110_100;
    localparam logic [8:0] P_CMP      = 9'b000_000_100;
    localparam logic [8:0] P_SUBX     = 9'b100_100_100;
    localparam logic [8:0] P_SUBY     = 9'b011_010_100;
    localparam logic [8:0] P_OUT      = 9'b000_001_100;
    localparam logic [8:0] P_DONE     = 9'b000_000_010;
    localparam logic [8:0] P_DONE_ERR = 9'b000_000_011;

    wire [8:0] outs = {sx_o, sy_o, ssub_o, enx_o, eny_o, enobeb_o, busy_o, done_o, err_o};

    gcd_controller dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .ack_i   (ack_i),
        .xbig_i  (xbig_i),
        .ybig_i  (ybig_i),
        .eq_i    (eq_i),
        .sx_o    (sx_o),
        .sy_o    (sy_o),
        .ssub_o  (ssub_o),
        .enx_o   (enx_o),
        .eny_o   (eny_o),
        .enobeb_o(enobeb_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Environment: datapath registers driven by the controller's selects and enables.
    always_ff @(posedge clk_i) begin
        if (enx_o) dp_x <= sx_o ? (ssub_o ? dp_y - dp_x : dp_x - dp_y) : op_a;
        if (eny_o) dp_y <= sy_o ? (ssub_o ? dp_y - dp_x : dp_x - dp_y) : op_b;
        if (enobeb_o) dp_obeb <= dp_x;
    end
    assign eq_i   = (dp_x == dp_y) && (dp_x != 4'd0);
    assign xbig_i = dp_x > dp_y;
    assign ybig_i = dp_y > dp_x;

    // Reference: Euclid by repeated subtraction with an optional subtraction cap.
    function automatic void ref_run(input int a, input int b, output int nx, output int ny,
                                    output int g, output bit err);
        nx = 0; ny = 0; err = 1'b0;
        while (a != b || a == 0) begin
            if (nx + ny == REF_LIMIT) begin err = 1'b1; break; end
            if (b > a) begin b = b - a; ny++; end
            else if (a > b) begin a = a - b; nx++; end
            else break;
        end
        g = a;
    endfunction

    task automatic run_op(input int a, input int b, input bit do_ack, input bit noise);
        int nx, ny, g, exp_edges, edges, subx, suby, outs_seen;
        bit err, bad;
        ref_run(a, b, nx, ny, g, err);
        exp_edges = 2 * (nx + ny) + (err ? 2 : 3);
        op_a = 4'(a); op_b = 4'(b);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        checks++;
        if (outs !== P_LOAD) begin
            errors++; $display("FAIL load_%0d_%0d got %b want %b", a, b, outs, P_LOAD);
        end
        edges = 0; subx = 0; suby = 0; outs_seen = 0; bad = 1'b0;
        while (done_o !== 1'b1 && edges < exp_edges + 10) begin
            if (noise) begin
                start_i = 1'($urandom_range(0, 1));
                ack_i   = 1'($urandom_range(0, 1));
            end
            @(posedge clk_i); #1;
            edges++;
            if (outs === P_SUBX) subx++;
            if (outs === P_SUBY) suby++;
            if (outs === P_OUT) outs_seen++;
            if (!(outs inside {P_LOAD, P_CMP, P_SUBX, P_SUBY, P_OUT, P_DONE, P_DONE_ERR})) bad = 1'b1;
        end
        start_i = 1'b0; ack_i = 1'b0;
        checks++;
        if (edges != exp_edges) begin
            errors++; $display("FAIL latency_%0d_%0d got %0d want %0d", a, b, edges, exp_edges);
        end
        checks++;
        if (subx != nx || suby != ny) begin
            errors++; $display("FAIL subs_%0d_%0d got x%0d/y%0d want x%0d/y%0d", a, b, subx, suby, nx, ny);
        end
        checks++;
        if (outs_seen != (err ? 0 : 1)) begin
            errors++; $display("FAIL out_visits_%0d_%0d got %0d want %0d", a, b, outs_seen, err ? 0 : 1);
        end
        checks++;
        if (done_o !== 1'b1 || err_o !== err) begin
            errors++; $display("FAIL done_err_%0d_%0d got %b%b want 1%b", a, b, done_o, err_o, err);
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL decode_%0d_%0d got illegal output pattern want legal", a, b);
        end
        if (!err) begin
            checks++;
            if (dp_obeb !== 4'(g)) begin
                errors++; $display("FAIL obeb_%0d_%0d got %0d want %0d", a, b, dp_obeb, g);
            end
        end
        if (do_ack) begin
            ack_i = 1'b1;
            @(posedge clk_i); #1;
            ack_i = 1'b0;
            checks++;
            if (outs !== P_IDLE) begin
                errors++; $display("FAIL ack_%0d_%0d got %b want %b", a, b, outs, P_IDLE);
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b0; ack_i = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (outs !== P_IDLE) begin errors++; $display("FAIL reset_outs got %b want %b", outs, P_IDLE); end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (outs !== P_IDLE) begin errors++; $display("FAIL idle_after_reset got %b want %b", outs, P_IDLE); end
    endtask

    task automatic test_directed();
        run_op(12, 8, 1'b1, 1'b0);
        run_op(5, 5, 1'b1, 1'b0);
        run_op(7, 1, 1'b1, 1'b0);
    endtask

    task automatic test_zero_operand();
`ifdef GCD_CTRL_ITER_LIMIT_EN
        run_op(0, 5, 1'b1, 1'b0);
`else
        bit stuck_busy;
        op_a = 4'd0; op_b = 4'd5;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        stuck_busy = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk_i); #1;
            if (busy_o !== 1'b1 || done_o !== 1'b0) stuck_busy = 1'b0;
        end
        checks++;
        if (!stuck_busy) begin errors++; $display("FAIL zero_loops got busy drop want busy 120 cycles"); end
        rst_ni = 1'b0; #1;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
`endif
    endtask

    task automatic test_reset_mid();
        bit found;
        op_a = 4'd3; op_b = 4'd7;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk_i); #1;
            if (outs === P_SUBY) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL reach_suby got 0 want 1"); end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (outs !== P_IDLE) begin errors++; $display("FAIL async_reset got %b want %b", outs, P_IDLE); end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (outs !== P_IDLE) begin errors++; $display("FAIL idle_after_abort got %b want %b", outs, P_IDLE); end
        run_op(6, 4, 1'b1, 1'b0);
    endtask

    task automatic test_done_hold();
        int edges;
        run_op(12, 8, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (outs !== P_DONE || dp_obeb !== 4'd4) begin
                errors++; $display("FAIL done_hold_%0d got %b/%0d want %b/4", i, outs, dp_obeb, P_DONE);
            end
        end
        start_i = 1'b1; ack_i = 1'b1;
        @(posedge clk_i); #1;
        ack_i = 1'b0;
        checks++;
        if (outs !== P_IDLE) begin errors++; $display("FAIL ack_wins got %b want %b", outs, P_IDLE); end
        @(posedge clk_i); #1;
        start_i = 1'b0;
        checks++;
        if (outs !== P_LOAD) begin errors++; $display("FAIL restart_load got %b want %b", outs, P_LOAD); end
        edges = 0;
        while (done_o !== 1'b1 && edges < 20) begin
            @(posedge clk_i); #1;
            edges++;
        end
        checks++;
        if (edges != 7 || dp_obeb !== 4'd4) begin
            errors++; $display("FAIL restart_result got %0d edges obeb %0d want 7 edges obeb 4", edges, dp_obeb);
        end
        ack_i = 1'b1;
        @(posedge clk_i); #1;
        ack_i = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_op(int'($urandom_range(1, 7)), int'($urandom_range(1, 7)), 1'b1, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_operand();
        test_reset_mid();
        test_done_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
